// File: rtl/mem_instr_sync.sv
// ---------------------------------------------------------------------------
// mem_instr_sync
//
// Clocked instruction memory for the fetch stage. It accepts one fetch
// request at a time, adds WAIT_STATES extra cycles to each fetch, and returns
// the word together with an error flag. A separate write port loads the
// program.
//
// Handshake: a fetch is accepted at a rising edge where ReadMem is low and
// busy is low. Its response is presented as a one-cycle rsp_valid pulse
// WAIT_STATES+1 cycles after acceptance. Dato_Instru and rsp_err are
// meaningful only while rsp_valid is high and hold their value otherwise.
// While busy is high, requests are ignored and are not queued.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   ReadMem      fetch request, active-low
//   Dir_Instru   fetch byte address
//   Dato_Instru  fetched word (FILL_WORD on an erroneous fetch)
//   rsp_valid    one-cycle response strobe
//   rsp_err      fetch was out of range or misaligned (qualified by rsp_valid)
//   busy         a request presented now is ignored
//   wr_en        program-load write strobe, active-high
//   wr_addr      write byte address
//   wr_data      write data
//   dbg_state_o  current fetch FSM state (IDLE=0, WAIT=1, RESP=2)
// ---------------------------------------------------------------------------
module mem_instr_sync #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                DEPTH       = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(32'h00400000),
  parameter int                WAIT_STATES = 0,
  parameter logic [DATA_W-1:0] FILL_WORD   = DATA_W'(32'hFFFFFFFF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ReadMem,
  input  logic [ADDR_W-1:0] Dir_Instru,
  output logic [DATA_W-1:0] Dato_Instru,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic              busy,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [1:0]        dbg_state_o
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);

  // Decode works one bit wider than the address so that an address below
  // the base shows up as a set top bit instead of wrapping into range.
  localparam logic [ADDR_W:0] BASE_EXT   = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] ALIGN_MASK = (ADDR_W+1)'(BYTES - 1);
  localparam logic [ADDR_W:0] DEPTH_EXT  = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]      CNT_LOAD   = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Storage: not reset, so a loaded program survives a reset.
  logic [DATA_W-1:0] mem_q [DEPTH];

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic [DATA_W-1:0] res_data_q;
  logic              res_err_q;
  logic [DATA_W-1:0] dato_q;
  logic              err_q;
  logic              rsp_valid_q;
  logic              busy_q;

  // ---------------------------------------------------------------------
  // Fetch address decode
  // ---------------------------------------------------------------------
  logic [ADDR_W:0]   fet_off_d;
  logic [ADDR_W:0]   fet_word_d;
  logic [IDX_W-1:0]  fet_idx_d;
  logic              fet_bad_d;
  logic [DATA_W-1:0] fet_data_d;

  always_comb begin
    fet_off_d  = {1'b0, Dir_Instru} - BASE_EXT;
    fet_word_d = fet_off_d >> OFF_W;
    fet_idx_d  = fet_word_d[IDX_W-1:0];
    // Underflow, misalignment or a word index at/after DEPTH. The full
    // word index is compared so high address bits never alias.
    fet_bad_d  = fet_off_d[ADDR_W]
               | (|(fet_off_d & ALIGN_MASK))
               | (fet_word_d >= DEPTH_EXT);
    fet_data_d = fet_bad_d ? FILL_WORD : mem_q[fet_idx_d];
  end

  // ---------------------------------------------------------------------
  // Write address decode
  // ---------------------------------------------------------------------
  logic [ADDR_W:0]  wr_off_d;
  logic [ADDR_W:0]  wr_word_d;
  logic [IDX_W-1:0] wr_idx_d;
  logic             wr_ok_d;

  always_comb begin
    wr_off_d  = {1'b0, wr_addr} - BASE_EXT;
    wr_word_d = wr_off_d >> OFF_W;
    wr_idx_d  = wr_word_d[IDX_W-1:0];
    wr_ok_d   = wr_en
              & ~wr_off_d[ADDR_W]
              & ~(|(wr_off_d & ALIGN_MASK))
              & (wr_word_d < DEPTH_EXT);
  end

  // Array write. The fetch path reads mem_q combinationally before this
  // edge updates it, so a same-edge write/fetch returns the old word.
  always_ff @(posedge clk) begin
    if (wr_ok_d) begin
      mem_q[wr_idx_d] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------
  // Fetch FSM
  // ---------------------------------------------------------------------
  logic fetch_req_d;
  assign fetch_req_d = ~ReadMem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      dato_q      <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // Strobes are rebuilt every cycle from the state being entered.
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      case (state_q)
        S_IDLE, S_RESP: begin
          if (fetch_req_d) begin
            if (WAIT_STATES == 0) begin
              state_q     <= S_RESP;
              dato_q      <= fet_data_d;
              err_q       <= fet_bad_d;
              rsp_valid_q <= 1'b1;
            end else begin
              // Result is captured now; the array may change during WAIT.
              state_q    <= S_WAIT;
              cnt_q      <= CNT_LOAD;
              res_data_q <= fet_data_d;
              res_err_q  <= fet_bad_d;
              busy_q     <= 1'b1;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q     <= S_RESP;
            dato_q      <= res_data_q;
            err_q       <= res_err_q;
            rsp_valid_q <= 1'b1;
          end else begin
            cnt_q  <= cnt_q - 4'd1;
            busy_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign Dato_Instru = dato_q;
  assign rsp_err     = err_q;
  assign rsp_valid   = rsp_valid_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;

endmodule
